// File: rtl/rtype_instr_gen.sv
// Pseudo-random RV32I R-type instruction source for core imem stimulus.
// A Galois LFSR supplies the fields; the source stops after NUM_INSTRS issues.
module rtype_instr_gen #(
    parameter logic [31:0] SEED       = 32'd324,
    parameter logic [31:0] NUM_INSTRS = 32'd100
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    output logic [31:0] o_issued_count,
    output logic        o_done
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_RUN    = 2'd1;
    localparam logic [1:0]  ST_DONE   = 2'd2;
    localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0]  OP_RTYPE  = 7'b0110011;

    logic [1:0]  r_state;
    logic [31:0] r_lfsr;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic [31:0] r_issued_count;
    logic        r_done;

    logic [1:0]  w_next_state;
    logic        w_issue;
    logic        w_last;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_rtype;
    logic        w_unused_lfsr_hi;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'd0);
    endfunction

    // Bits above the rs2/alt fields only feed the LFSR recurrence.
    assign w_unused_lfsr_hi = ^r_lfsr[31:19];

    // Issue decision and instruction assembly from the pre-advance LFSR.
    always_comb begin
        w_issue  = ((r_state == ST_IDLE) || (r_state == ST_RUN)) && i_enable
                   && (r_issued_count < NUM_INSTRS);
        w_last   = w_issue && ((r_issued_count + 32'd1) == NUM_INSTRS);
        w_funct3 = r_lfsr[7:5];
        if (r_lfsr[18] && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))) begin
            w_funct7 = 7'b0100000;
        end else begin
            w_funct7 = 7'b0000000;
        end
        w_rtype = {w_funct7, r_lfsr[17:13], r_lfsr[12:8], w_funct3, r_lfsr[4:0], OP_RTYPE};
    end

    // Next-state logic; the final issue goes straight to DONE even from IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    if ((NUM_INSTRS == 32'd0) || w_last) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: w_next_state = ST_DONE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, LFSR and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_lfsr         <= SEED_EFF;
            r_instr        <= NOP_INSTR;
            r_instr_valid  <= 1'b0;
            r_issued_count <= 32'd0;
            r_done         <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (w_next_state == ST_DONE);
            if (w_issue) begin
                r_instr        <= w_rtype;
                r_instr_valid  <= 1'b1;
                r_issued_count <= r_issued_count + 32'd1;
                r_lfsr         <= lfsr_next(r_lfsr);
            end else begin
                r_instr        <= NOP_INSTR;
                r_instr_valid  <= 1'b0;
                r_issued_count <= r_issued_count;
                r_lfsr         <= r_lfsr;
            end
        end
    end

    assign o_instr        = r_instr;
    assign o_instr_valid  = r_instr_valid;
    assign o_issued_count = r_issued_count;
    assign o_done         = r_done;

endmodule

// File: tb/tb_rtype_instr_gen.sv
// Scoreboard bench for rtype_instr_gen: a long-run instance plus small
// NUM_INSTRS=3 (SEED=0) and NUM_INSTRS=0 instances for the completion cases.
module tb_rtype_instr_gen;

    localparam logic [31:0] NUM_A = 32'd10200;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic [31:0] instr_a, instr_b, instr_c;
    logic        valid_a, valid_b, valid_c;
    logic [31:0] cnt_a, cnt_b, cnt_c;
    logic        done_a, done_b, done_c;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic        valid;
        logic [31:0] cnt;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_lfsr;
    logic [31:0] m_cnt;
    logic        m_done;

    always #5 clk = ~clk;

    rtype_instr_gen #(.SEED(32'd1), .NUM_INSTRS(NUM_A)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_enable(en_a),
        .o_instr(instr_a), .o_instr_valid(valid_a),
        .o_issued_count(cnt_a), .o_done(done_a)
    );

    rtype_instr_gen #(.SEED(32'd0), .NUM_INSTRS(32'd3)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_enable(en_b),
        .o_instr(instr_b), .o_instr_valid(valid_b),
        .o_issued_count(cnt_b), .o_done(done_b)
    );

    rtype_instr_gen #(.SEED(32'd5), .NUM_INSTRS(32'd0)) dut_c (
        .i_clk(clk), .i_reset(reset), .i_enable(en_c),
        .o_instr(instr_c), .o_instr_valid(valid_c),
        .o_issued_count(cnt_c), .o_done(done_c)
    );

    function automatic logic [31:0] model_instr(input logic [31:0] s);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = s[7:5];
        f7 = (s[18] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00;
        return {f7, s[17:13], s[12:8], f3, s[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    // Drive one cycle of dut_a, push the model's expectation, wait to the sample point.
    task automatic drive_a(input logic en);
        exp_t e;
        logic issue;
        @(negedge clk);
        en_a  = en;
        issue = !m_done && en && (m_cnt < NUM_A);
        e.instr = issue ? model_instr(m_lfsr) : NOP;
        e.valid = issue;
        if (issue) begin
            m_lfsr = model_next(m_lfsr);
            m_cnt  = m_cnt + 32'd1;
            if (m_cnt == NUM_A) m_done = 1'b1;
        end
        e.cnt  = m_cnt;
        e.done = m_done;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset = 1'b1;
            en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
            @(posedge clk);
            #1;
            n_checks++;
            if (instr_a !== NOP || valid_a !== 1'b0 || cnt_a !== 32'd0 || done_a !== 1'b0 ||
                instr_b !== NOP || instr_c !== NOP) begin
                $display("FAIL reset_state: a instr=%h valid=%b cnt=%0d done=%b b=%h c=%h, required instr=%h valid=0 cnt=0 done=0",
                         instr_a, valid_a, cnt_a, done_a, instr_b, instr_c, NOP);
            end else n_pass++;
        end
        @(negedge clk);
        reset = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        m_lfsr = 32'd1;
        m_cnt  = 32'd0;
        m_done = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_basic();
        exp_t e;
        logic [31:0] want_const [2];
        want_const[0] = 32'h0000_00B3;
        want_const[1] = 32'h0000_01B3;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b1);
            e = sb.pop_front();
            n_checks++;
            if (instr_a !== want_const[i] || instr_a !== e.instr || valid_a !== 1'b1 ||
                cnt_a !== (i + 1)) begin
                $display("FAIL basic_%0d: instr=%h valid=%b cnt=%0d, required instr=%h valid=1 cnt=%0d",
                         i, instr_a, valid_a, cnt_a, want_const[i], i + 1);
            end else n_pass++;
        end
    endtask

    task automatic test_stall();
        exp_t e;
        logic [31:0] want [3];
        logic        wen  [3];
        want[0] = 32'h0000_00B3; want[1] = NOP; want[2] = 32'h0000_01B3;
        wen[0] = 1'b1; wen[1] = 1'b0; wen[2] = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_a(wen[i]);
            e = sb.pop_front();
            n_checks++;
            if (instr_a !== want[i] || instr_a !== e.instr || valid_a !== wen[i] ||
                cnt_a !== e.cnt) begin
                $display("FAIL stall_%0d: instr=%h valid=%b cnt=%0d, required instr=%h valid=%b cnt=%0d",
                         i, instr_a, valid_a, cnt_a, want[i], wen[i], e.cnt);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        logic [31:0] first_run [50];
        do_reset();
        for (int i = 0; i < 50; i++) begin
            drive_a(1'b1);
            e = sb.pop_front();
            first_run[i] = instr_a;
            n_checks++;
            if (instr_a !== e.instr || cnt_a !== e.cnt) begin
                $display("FAIL run1_%0d: instr=%h cnt=%0d, required instr=%h cnt=%0d",
                         i, instr_a, cnt_a, e.instr, e.cnt);
            end else n_pass++;
        end
        do_reset();
        for (int i = 0; i < 50; i++) begin
            drive_a(1'b1);
            e = sb.pop_front();
            n_checks++;
            if (instr_a !== first_run[i] || instr_a !== e.instr || cnt_a !== e.cnt) begin
                $display("FAIL rerun_%0d: instr=%h cnt=%0d, required instr=%h cnt=%0d",
                         i, instr_a, cnt_a, e.instr, e.cnt);
            end else n_pass++;
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [7:0]  f3_seen;
        logic [31:0] rd_seen, rs1_seen, rs2_seen;
        f3_seen = 8'h00; rd_seen = 32'h0; rs1_seen = 32'h0; rs2_seen = 32'h0;
        do_reset();
        for (int c = 0; c < 20000 && m_cnt < 32'd10000; c++) begin
            drive_a($urandom_range(0, 3) != 0);
            e = sb.pop_front();
            n_checks++;
            if (instr_a !== e.instr || valid_a !== e.valid || cnt_a !== e.cnt || done_a !== e.done) begin
                $display("FAIL random_cycle_%0d: instr=%h valid=%b cnt=%0d done=%b, required instr=%h valid=%b cnt=%0d done=%b",
                         c, instr_a, valid_a, cnt_a, done_a, e.instr, e.valid, e.cnt, e.done);
            end else n_pass++;
            if (valid_a === 1'b1) begin
                n_checks++;
                if (instr_a[6:0] !== 7'b0110011 ||
                    (instr_a[31:25] !== 7'h00 && instr_a[14:12] !== 3'd0 && instr_a[14:12] !== 3'd5)) begin
                    $display("FAIL random_fields_%0d: instr=%h, required opcode 33 and funct7 zero unless funct3 is 0/5",
                             c, instr_a);
                end else n_pass++;
                f3_seen[instr_a[14:12]]  = 1'b1;
                rd_seen[instr_a[11:7]]   = 1'b1;
                rs1_seen[instr_a[19:15]] = 1'b1;
                rs2_seen[instr_a[24:20]] = 1'b1;
            end
        end
        n_checks++;
        if (cnt_a !== 32'd10000) begin
            $display("FAIL random_count: issued=%0d, required 10000", cnt_a);
        end else n_pass++;
        n_checks++;
        if (f3_seen !== 8'hFF || rd_seen !== 32'hFFFF_FFFF || rs1_seen !== 32'hFFFF_FFFF ||
            rs2_seen !== 32'hFFFF_FFFF) begin
            $display("FAIL random_coverage: f3=%h rd=%h rs1=%h rs2=%h, required all ones",
                     f3_seen, rd_seen, rs1_seen, rs2_seen);
        end else n_pass++;
    endtask

    task automatic test_num3();
        logic [31:0] want_i [6];
        logic        want_v [6];
        logic [31:0] want_c [6];
        logic        want_d [6];
        want_i[0] = 32'h0000_00B3; want_i[1] = 32'h0000_01B3; want_i[2] = 32'h0000_0133;
        for (int i = 0; i < 6; i++) begin
            if (i >= 3) want_i[i] = NOP;
            want_v[i] = (i < 3);
            want_c[i] = (i < 3) ? (i + 1) : 3;
            want_d[i] = (i >= 2);
        end
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en_b = (i != 4);
            @(posedge clk);
            #1;
            n_checks++;
            if (instr_b !== want_i[i] || valid_b !== want_v[i] || cnt_b !== want_c[i] ||
                done_b !== want_d[i]) begin
                $display("FAIL num3_%0d: instr=%h valid=%b cnt=%0d done=%b, required instr=%h valid=%b cnt=%0d done=%b",
                         i, instr_b, valid_b, cnt_b, done_b, want_i[i], want_v[i], want_c[i], want_d[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_num0();
        do_reset();
        @(negedge clk);
        en_c = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (done_c !== 1'b0 || valid_c !== 1'b0) begin
            $display("FAIL num0_idle: done=%b valid=%b, required done=0 valid=0", done_c, valid_c);
        end else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en_c = 1'b1;
            @(posedge clk);
            #1;
            n_checks++;
            if (instr_c !== NOP || valid_c !== 1'b0 || cnt_c !== 32'd0 || done_c !== 1'b1) begin
                $display("FAIL num0_%0d: instr=%h valid=%b cnt=%0d done=%b, required instr=%h valid=0 cnt=0 done=1",
                         i, instr_c, valid_c, cnt_c, done_c, NOP);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_reset_midrun();
        test_num3();
        test_num0();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rtype_instr_gen.md
RTYPE_INSTR_GEN -- requirements
Module: rtype_instr_gen

Interface
REQ-001 Parameter SEED, default 32'd324, initial LFSR state; a value of 0 SHALL be replaced by 32'd1.
REQ-002 Parameter NUM_INSTRS, default 32'd100, number of R-type instructions issued before completion.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  issue permission for the current cycle; low = stall.
REQ-006 instr  output  32  registered instruction word to the core imem response data.
REQ-007 instr_valid  output  1  high when instr carries a generated R-type instruction.
REQ-008 issued_count  output  32  number of instructions issued since reset.
REQ-009 done  output  1  high once NUM_INSTRS instructions have been issued.

Function
REQ-010 State machine SHALL have states IDLE, RUN and DONE, and reset SHALL enter IDLE.
REQ-011 IDLE SHALL go to RUN on enable=1 when NUM_INSTRS>0, go to DONE on enable=1 when NUM_INSTRS==0, and otherwise hold.
REQ-012 LFSR: 32-bit Galois, right-shift; next = (lfsr>>1) ^ (lfsr[0] ? 32'h80200003 : 0).
REQ-013 LFSR SHALL advance only in cycles where an instruction is issued.
REQ-014 Issue condition: (state==IDLE or RUN) and enable=1 and issued_count<NUM_INSTRS.
REQ-015 Field extraction on an issue, from the current (pre-advance) LFSR: rd=lfsr[4:0], funct3=lfsr[7:5], rs1=lfsr[12:8], rs2=lfsr[17:13], alt=lfsr[18].
REQ-016 funct7 SHALL be 7'b0100000 when alt=1 and funct3 is 3'b000 (SUB) or 3'b101 (SRA); otherwise funct7 SHALL be 7'b0000000.
REQ-017 On an issue, the next-cycle instr SHALL be {funct7, rs2, rs1, funct3, rd, 7'b0110011}, with instr_valid=1 and issued_count incremented by 1.
REQ-018 Latency: the instruction SHALL appear on instr exactly one cycle after the enable sample that issued it.
REQ-019 Any non-issue cycle (stall, IDLE without enable, DONE) SHALL drive instr=32'h00000013 (NOP) and instr_valid=0 in the next cycle, with the LFSR and issued_count held.
REQ-020 RUN SHALL go to DONE in the cycle in which the issue that makes issued_count equal NUM_INSTRS occurs.
REQ-021 done SHALL be registered and rise in the same cycle the last instruction appears on instr.
REQ-022 DONE is absorbing: only reset exits it, and enable is ignored.
REQ-023 rd, rs1 and rs2 SHALL be unrestricted (x0 allowed); writes to x0 are the core's concern.
REQ-024 issued_count SHALL saturate at NUM_INSTRS and SHALL never wrap.

Reset
REQ-025 Reset SHALL set instr=32'h00000013, instr_valid=0, issued_count=0, done=0, state=IDLE and lfsr=SEED (or 1 when SEED is 0).
REQ-026 Reset asserted mid-RUN or in DONE SHALL take effect at the next edge, discard the in-flight sequence, and make the sequence restart identically from the seed.
REQ-027 While reset is high, instr SHALL stay NOP regardless of enable.

Verification
REQ-028 SEED=1, reset released, enable=1 held -> cycle 1 instr=32'h000000B3; cycle 2 instr=32'h000001B3; instr_valid=1 on both cycles; issued_count=1 then 2.
REQ-029 SEED=1, enable pulsed 1,0,1 -> instr sequence 0x000000B3, 0x00000013 (valid=0), 0x000001B3; LFSR held during the stall.
REQ-030 NUM_INSTRS=3, enable=1 held -> three valid instructions; done=1 with the third; then NOP, valid=0 and issued_count=3 forever.
REQ-031 NUM_INSTRS=0, enable=1 -> DONE next cycle; no valid instruction ever issued; issued_count=0.
REQ-032 Reset at issued_count=50 of 100 -> next cycle NOP, count=0; a rerun reproduces the first-run instruction sequence bit-exactly.
REQ-033 Random run of 10k instructions -> opcode always 7'b0110011; funct7 is nonzero only when funct3 is 0 or 5; every funct3 value and every register index observed.
